// File: rtl/sudoku_display.sv
// Display stage for the Sudoku row: four active-low 7-segment digits with a blinking cursor and an error LED.
// Latency: 2 cycles from inputs to HEX, 2 cycles noWrite to errLed; no backpressure, one row consumed every cycle.
module sudoku_display #(
  parameter int BLINK_HALF = 12_500_000,
  parameter int ERR_CYCLES = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] currentRow,
  input  logic [3:0]  currentNum,
  input  logic        noWrite,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0,
  output logic        errLed,
  output logic        blinkPhase
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int EW = $clog2(ERR_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [EW-1:0] ERR_LOAD   = EW'(ERR_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_UNDER = 7'h77;

  logic [15:0]   rowQ;
  logic [3:0]    numQ;
  logic          noWriteQ;
  logic [BW-1:0] blinkCnt;
  logic [EW-1:0] errCnt;
  logic [EW-1:0] errNext;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h7F;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // An empty cursor cell shows an underscore so the cursor never disappears entirely.
  function automatic logic [6:0] cellGlyph(input logic [3:0] v, input logic sel, input logic phase);
    logic [6:0] s;
    if (!sel)
      s = segOf(v);
    else if (!phase)
      s = SEG_BLANK;
    else if (v == 4'h0)
      s = SEG_UNDER;
    else
      s = segOf(v);
    return s;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rowQ     <= '0;
      numQ     <= '0;
      noWriteQ <= 1'b0;
    end else begin
      rowQ     <= currentRow;
      numQ     <= currentNum;
      noWriteQ <= noWrite;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b1;
    end else if (blinkCnt == BLINK_LAST) begin
      blinkCnt   <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCnt   <= blinkCnt + BW'(1);
    end
  end

  always_comb begin
    errNext = errCnt;
    if (noWriteQ)
      errNext = ERR_LOAD;
    else if (errCnt != '0)
      errNext = errCnt - EW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      errCnt <= '0;
      errLed <= 1'b0;
    end else begin
      errCnt <= errNext;
      errLed <= (errNext != '0);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HEX3 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX0 <= SEG_BLANK;
    end else begin
      HEX3 <= cellGlyph(rowQ[15:12], numQ[3], blinkPhase);
      HEX2 <= cellGlyph(rowQ[11:8],  numQ[2], blinkPhase);
      HEX1 <= cellGlyph(rowQ[7:4],   numQ[1], blinkPhase);
      HEX0 <= cellGlyph(rowQ[3:0],   numQ[0], blinkPhase);
    end
  end

endmodule

// File: tb/tb_sudoku_display.sv
// Bench for sudoku_display: directed scenarios plus random rows, checked every cycle
// against a model built from edge counts since reset (blink phase, error window, glyph table).
module tb_sudoku_display;

  localparam int BH  = 4;
  localparam int ERR = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] currentRow = '0;
  logic [3:0]  currentNum = '0;
  logic        noWrite = 1'b0;
  logic [6:0]  HEX3, HEX2, HEX1, HEX0;
  logic        errLed, blinkPhase;

  int tests = 0;
  int fails = 0;

  // model state
  int          t;
  logic [15:0] sRow;
  logic [3:0]  sNum;
  bit          hasNw;
  int          lastNw;
  bit          lastErrExp, lastBpExp;

  logic [6:0] segTab [16] = '{7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sudoku_display #(.BLINK_HALF(BH), .ERR_CYCLES(ERR)) dut (
    .CLK(CLK), .RST(RST), .currentRow(currentRow), .currentNum(currentNum), .noWrite(noWrite),
    .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .errLed(errLed), .blinkPhase(blinkPhase)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, t);
    end
  endtask

  function automatic bit bpAt(input int n);
    return ((n / BH) % 2) == 0;
  endfunction

  function automatic logic [6:0] expGlyph(input logic [3:0] v, input bit sel, input bit ph);
    if (sel && !ph) return 7'h7F;
    if (sel && v == 4'h0) return 7'h77;
    return segTab[v];
  endfunction

  task automatic resetModel();
    t = 0; sRow = '0; sNum = '0; hasNw = 0; lastNw = 0;
  endtask

  task automatic step();
    logic [6:0] e [4];
    bit eErr, eBp;
    @(posedge CLK);
    t++;
    for (int d = 0; d < 4; d++) e[d] = expGlyph(sRow[4*d +: 4], sNum[d], bpAt(t - 1));
    eErr = hasNw && ((t - lastNw) <= ERR);
    sRow = currentRow;
    sNum = currentNum;
    if (noWrite) begin hasNw = 1; lastNw = t; end
    eBp = bpAt(t);
    #1;
    check("HEX3", 32'(HEX3), 32'(e[3]));
    check("HEX2", 32'(HEX2), 32'(e[2]));
    check("HEX1", 32'(HEX1), 32'(e[1]));
    check("HEX0", 32'(HEX0), 32'(e[0]));
    check("errLed", 32'(errLed), 32'(eErr));
    check("blinkPhase", 32'(blinkPhase), 32'(eBp));
    lastErrExp = eErr;
    lastBpExp  = eBp;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_HEX3"}, 32'(HEX3), 32'h7F);
    check({tag, "_HEX2"}, 32'(HEX2), 32'h7F);
    check({tag, "_HEX1"}, 32'(HEX1), 32'h7F);
    check({tag, "_HEX0"}, 32'(HEX0), 32'h7F);
    check({tag, "_errLed"}, 32'(errLed), 32'h0);
    check({tag, "_blink"}, 32'(blinkPhase), 32'h1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    resetModel();
    currentRow = 16'h1200;
    currentNum = 4'b0001;
    #1 RST = 1'b1;
    #2 checkResetState("rst");
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    resetModel();

    // empty cursor cell: underscore / blank
    run(20);
    // nonzero cursor cell blinks, others steady
    currentNum = 4'b1000;
    run(20);
    // data latency with no cursor
    currentNum = 4'b0000;
    currentRow = 16'h0000;
    run(3);
    currentRow = 16'hABCD;
    run(4);

    // single error pulse, then retrigger 3 cycles later, then held high
    currentRow = 16'h5678;
    noWrite = 1'b1; step(); noWrite = 1'b0;
    run(8);
    noWrite = 1'b1; step(); noWrite = 1'b0;
    run(2);
    noWrite = 1'b1; step(); noWrite = 1'b0;
    run(8);
    noWrite = 1'b1; run(4); noWrite = 1'b0;
    run(8);

    // cursor edge cases
    currentRow = 16'h0F30;
    currentNum = 4'b0000;
    run(20);
    currentNum = 4'b0101;
    run(20);

    // reset during an active hold and blanked phase
    currentNum = 4'b1111;
    noWrite = 1'b1;
    found = 0;
    for (int i = 0; i < 3 * BH && !found; i++) begin
      step();
      if (lastErrExp && !lastBpExp) found = 1;
    end
    noWrite = 1'b0;
    check("midrst_setup_err", 32'(errLed), 32'h1);
    check("midrst_setup_blink", 32'(blinkPhase), 32'h0);
    #2 RST = 1'b1;
    #1 checkResetState("midrst");
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    resetModel();
    run(12);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      currentRow = 16'($urandom);
      currentNum = 4'($urandom_range(0, 15));
      noWrite    = ($urandom_range(0, 9) == 0);
      step();
    end
    noWrite = 1'b0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
